// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multicycle RV32I controller and its datapath/memory.
// The controller uses the master modport; the datapath side uses slave.
interface multicycle_ctrl_if;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic        zero;
   logic        mem_ready;
   logic        mem_req;
   logic        mem_we;
   logic        iord;
   logic        ir_we;
   logic        pc_we;
   logic        pc_src;
   logic [1:0]  alu_a_sel;
   logic [1:0]  alu_b_sel;
   logic [1:0]  alu_op_sel;
   logic        reg_we;
   logic [1:0]  wb_sel;
   logic [2:0]  state;
   logic        halted;
   logic        illegal;
   logic        bus_err;
   logic [31:0] instret;

   modport master (
      input  opcode, funct3, zero, mem_ready,
      output mem_req, mem_we, iord, ir_we, pc_we, pc_src,
             alu_a_sel, alu_b_sel, alu_op_sel, reg_we, wb_sel,
             state, halted, illegal, bus_err, instret
   );

   modport slave (
      output opcode, funct3, zero, mem_ready,
      input  mem_req, mem_we, iord, ir_we, pc_we, pc_src,
             alu_a_sel, alu_b_sel, alu_op_sel, reg_we, wb_sel,
             state, halted, illegal, bus_err, instret
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// Phase sequencer for a multicycle RV32I datapath sharing one memory port.
// Handles variable memory latency with a timeout, counts retirements, halts on faults.
module multicycle_ctrl #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   multicycle_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_SYS   = 7'b1110011;

   localparam logic [1:0] A_PC      = 2'd0;
   localparam logic [1:0] A_RS1     = 2'd1;
   localparam logic [1:0] A_OLDPC   = 2'd2;
   localparam logic [1:0] A_ZERO    = 2'd3;
   localparam logic [1:0] B_RS2     = 2'd0;
   localparam logic [1:0] B_FOUR    = 2'd1;
   localparam logic [1:0] B_IMM     = 2'd2;
   localparam logic [1:0] ALU_ADD   = 2'd0;
   localparam logic [1:0] ALU_FUNCT = 2'd1;
   localparam logic [1:0] ALU_SUB   = 2'd2;
   localparam logic [1:0] WB_ALUOUT = 2'd0;
   localparam logic [1:0] WB_MDR    = 2'd1;
   localparam logic [1:0] WB_PC     = 2'd2;

   localparam int             TW      = $clog2(MEM_TIMEOUT);
   localparam logic [TW-1:0]  TO_LAST = TW'(MEM_TIMEOUT - 1);

   state_t        r_state;
   state_t        w_next;
   logic [TW-1:0] r_wait_cnt;
   logic          r_illegal;
   logic          r_bus_err;
   logic [31:0]   r_instret;

   logic          w_mem_phase;
   logic          w_ready;
   logic          w_timeout;
   logic          w_is_legal;
   logic          w_is_system;
   logic          w_taken;
   logic          w_retire;
   logic          w_set_illegal;
   logic          w_set_bus_err;

   logic          w_mem_req;
   logic          w_mem_we;
   logic          w_iord;
   logic          w_ir_we;
   logic          w_pc_we;
   logic          w_pc_src;
   logic [1:0]    w_alu_a_sel;
   logic [1:0]    w_alu_b_sel;
   logic [1:0]    w_alu_op_sel;
   logic          w_reg_we;
   logic [1:0]    w_wb_sel;

   // mem_ready only counts while a request is actually outstanding
   assign w_mem_phase = (r_state == S_FETCH) || (r_state == S_MEM);
   assign w_ready     = w_mem_phase && bus.mem_ready;
   assign w_timeout   = w_mem_phase && !bus.mem_ready && (r_wait_cnt == TO_LAST);

   assign w_is_legal  = (bus.opcode == OP_R)     || (bus.opcode == OP_I)   ||
                        (bus.opcode == OP_LOAD)  || (bus.opcode == OP_STORE) ||
                        (bus.opcode == OP_LUI)   || (bus.opcode == OP_JAL) ||
                        ((bus.opcode == OP_BR) &&
                         ((bus.funct3 == 3'b000) || (bus.funct3 == 3'b001)));
   assign w_is_system = (bus.opcode == OP_SYS) && (bus.funct3 == 3'b000);
   assign w_taken     = bus.zero ^ bus.funct3[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next        = r_state;
      w_set_illegal = 1'b0;
      w_set_bus_err = 1'b0;
      case (r_state)
         S_FETCH: begin
            if (w_ready) begin
               w_next = S_DECODE;
            end else if (w_timeout) begin
               w_next        = S_HALT;
               w_set_bus_err = 1'b1;
            end
         end
         S_DECODE: begin
            if (w_is_legal) begin
               w_next = S_EXEC;
            end else begin
               w_next        = S_HALT;
               w_set_illegal = !w_is_system;
            end
         end
         S_EXEC: begin
            case (bus.opcode)
               OP_LOAD, OP_STORE:        w_next = S_MEM;
               OP_BR:                    w_next = S_FETCH;
               OP_R, OP_I, OP_LUI, OP_JAL: w_next = S_WB;
               default: begin
                  w_next        = S_HALT;
                  w_set_illegal = 1'b1;
               end
            endcase
         end
         S_MEM: begin
            if (w_ready) begin
               w_next = (bus.opcode == OP_STORE) ? S_FETCH : S_WB;
            end else if (w_timeout) begin
               w_next        = S_HALT;
               w_set_bus_err = 1'b1;
            end
         end
         S_WB:    w_next = S_FETCH;
         S_HALT:  w_next = S_HALT;
         default: w_next = S_HALT;
      endcase
   end

   assign w_retire = (r_state != S_FETCH) && (w_next == S_FETCH);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wait_cnt <= '0;
         r_illegal  <= 1'b0;
         r_bus_err  <= 1'b0;
         r_instret  <= '0;
      end else begin
         if ((r_state == w_next) && w_mem_phase && !bus.mem_ready) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
         end else begin
            r_wait_cnt <= '0;
         end
         if (w_set_illegal) begin
            r_illegal <= 1'b1;
         end
         if (w_set_bus_err) begin
            r_bus_err <= 1'b1;
         end
         if (w_retire) begin
            r_instret <= r_instret + 32'd1;
         end
      end
   end

   always_comb begin
      w_mem_req    = 1'b0;
      w_mem_we     = 1'b0;
      w_iord       = 1'b0;
      w_ir_we      = 1'b0;
      w_pc_we      = 1'b0;
      w_pc_src     = 1'b0;
      w_alu_a_sel  = A_PC;
      w_alu_b_sel  = B_RS2;
      w_alu_op_sel = ALU_ADD;
      w_reg_we     = 1'b0;
      w_wb_sel     = WB_ALUOUT;
      case (r_state)
         S_FETCH: begin
            w_mem_req   = 1'b1;
            w_alu_b_sel = B_FOUR;
            w_ir_we     = w_ready;
            w_pc_we     = w_ready;
         end
         S_DECODE: begin
            w_alu_a_sel = A_OLDPC;
            w_alu_b_sel = B_IMM;
         end
         S_EXEC: begin
            case (bus.opcode)
               OP_R: begin
                  w_alu_a_sel  = A_RS1;
                  w_alu_op_sel = ALU_FUNCT;
               end
               OP_I: begin
                  w_alu_a_sel  = A_RS1;
                  w_alu_b_sel  = B_IMM;
                  w_alu_op_sel = ALU_FUNCT;
               end
               OP_LOAD, OP_STORE: begin
                  w_alu_a_sel = A_RS1;
                  w_alu_b_sel = B_IMM;
               end
               OP_LUI: begin
                  w_alu_a_sel = A_ZERO;
                  w_alu_b_sel = B_IMM;
               end
               OP_BR: begin
                  w_alu_a_sel  = A_RS1;
                  w_alu_op_sel = ALU_SUB;
                  w_pc_we      = w_taken;
                  w_pc_src     = w_taken;
               end
               OP_JAL: begin
                  w_pc_we  = 1'b1;
                  w_pc_src = 1'b1;
               end
               default: ;
            endcase
         end
         S_MEM: begin
            w_mem_req = 1'b1;
            w_iord    = 1'b1;
            w_mem_we  = (bus.opcode == OP_STORE);
         end
         S_WB: begin
            w_reg_we = 1'b1;
            if (bus.opcode == OP_LOAD) begin
               w_wb_sel = WB_MDR;
            end else if (bus.opcode == OP_JAL) begin
               w_wb_sel = WB_PC;
            end
         end
         default: ;
      endcase
      // Reset may land mid-cycle; nothing may be requested or written while it is held
      if (!rst_n) begin
         w_mem_req = 1'b0;
         w_mem_we  = 1'b0;
         w_ir_we   = 1'b0;
         w_pc_we   = 1'b0;
         w_reg_we  = 1'b0;
      end
   end

   assign bus.mem_req    = w_mem_req;
   assign bus.mem_we     = w_mem_we;
   assign bus.iord       = w_iord;
   assign bus.ir_we      = w_ir_we;
   assign bus.pc_we      = w_pc_we;
   assign bus.pc_src     = w_pc_src;
   assign bus.alu_a_sel  = w_alu_a_sel;
   assign bus.alu_b_sel  = w_alu_b_sel;
   assign bus.alu_op_sel = w_alu_op_sel;
   assign bus.reg_we     = w_reg_we;
   assign bus.wb_sel     = w_wb_sel;
   assign bus.state      = r_state;
   assign bus.halted     = (r_state == S_HALT);
   assign bus.illegal    = r_illegal;
   assign bus.bus_err    = r_bus_err;
   assign bus.instret    = r_instret;

endmodule
